// File: rtl/spi_pkg.sv
// spi_pkg: shared state encoding, command/response bytes and parameter limits for the SPI master
package spi_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, WAIT_NEXT, HOLD, GAP} state_t;
  localparam int DIV_W = 8;
  localparam logic [7:0] CMD_DBG_A = 8'hAA;
  localparam logic [7:0] CMD_DBG_B = 8'h55;
  localparam logic [7:0] CMD_WHO_AM_I = 8'hF8;
  localparam logic [7:0] RSP_DBG_A = 8'h55;
  localparam logic [7:0] RSP_DBG_B = 8'hAA;
  localparam logic [7:0] RSP_WHO_AM_I = 8'h8F;
  localparam int CLK_DIV_MIN = 2;
  localparam int CLK_DIV_MAX = 255;
  localparam int CS_GAP_MIN = 1;
  localparam int CS_GAP_MAX = 255;
  function automatic logic [7:0] cmd_rsp(input logic [7:0] c);
    return c == CMD_DBG_A ? RSP_DBG_A : c == CMD_DBG_B ? RSP_DBG_B : c == CMD_WHO_AM_I ? RSP_WHO_AM_I : c;
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: single-cycle tick every i_period cycles; held at zero while disabled so each state entry restarts it
module spi_clk_div
  import spi_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_period,
  output logic             o_tick
);
  logic [DIV_W-1:0] cnt;
  assign o_tick = i_en && cnt == i_period - DIV_W'(1);
  always_ff @(posedge i_clk)
    cnt <= (!i_rst_n || !i_en || o_tick) ? '0 : cnt + DIV_W'(1);
endmodule

// File: rtl/spi_master_cmd.sv
// spi_master_cmd: SPI mode 0 MSB-first master with byte valid/ready handshake and CS held across multi-byte transactions
module spi_master_cmd
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_data,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_busy,
  output logic       o_spi_m_sck,
  output logic       o_spi_m_cs_n,
  output logic       o_spi_m_mosi,
  input  logic       i_spi_m_miso
);
  state_t state;
  logic [7:0] tx_sr, rx_sr;
  logic [2:0] bit_cnt;
  logic last, tick, div_en, accept;
  logic [DIV_W-1:0] period;
  assign accept = i_tx_valid && o_tx_ready;
  assign div_en = state inside {SETUP, SHIFT, HOLD, GAP};
  assign period = state == GAP ? DIV_W'(CS_GAP) : DIV_W'(CLK_DIV);
  spi_clk_div u_div (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_en     (div_en),
    .i_period (period),
    .o_tick   (tick)
  );
  // Each bit period is a low half then a high half; the period closes on the falling edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state <= IDLE;
      o_spi_m_sck <= 1'b0;
      o_spi_m_cs_n <= 1'b1;
      o_spi_m_mosi <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data <= 8'h00;
      o_busy <= 1'b0;
      o_tx_ready <= 1'b1;
      tx_sr <= 8'h00;
      rx_sr <= 8'h00;
      bit_cnt <= 3'd0;
      last <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;
      case (state)
        IDLE, WAIT_NEXT: if (accept) begin
          state <= SETUP;
          tx_sr <= i_tx_data;
          last <= i_tx_last;
          o_spi_m_mosi <= i_tx_data[7];
          o_spi_m_cs_n <= 1'b0;
          bit_cnt <= 3'd7;
          o_tx_ready <= 1'b0;
          o_busy <= 1'b1;
        end
        SETUP: if (tick) state <= SHIFT;
        SHIFT: if (tick) begin
          if (!o_spi_m_sck) begin
            o_spi_m_sck <= 1'b1;
            rx_sr <= {rx_sr[6:0], i_spi_m_miso};
          end else begin
            o_spi_m_sck <= 1'b0;
            if (bit_cnt == 3'd0) begin
              o_rx_valid <= 1'b1;
              o_rx_data <= rx_sr;
              state <= last ? HOLD : WAIT_NEXT;
              o_tx_ready <= !last;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
              tx_sr <= {tx_sr[6:0], 1'b0};
              o_spi_m_mosi <= tx_sr[6];
            end
          end
        end
        HOLD: if (tick) begin
          state <= GAP;
          o_spi_m_cs_n <= 1'b1;
        end
        GAP: if (tick) begin
          state <= IDLE;
          o_busy <= 1'b0;
          o_tx_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_cmd.sv
// tb_spi_master_cmd: directed bench with a behavioural mode-0 command slave per DUT instance
module tb_spi_master_cmd;
  import spi_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] tx_valid = '0, tx_last = '0;
  logic [1:0] tx_ready, rx_valid, busy, sck, cs_n, mosi, miso;
  logic [7:0] tx_data[2];
  logic [7:0] rx_data[2];
  int checks = 0, failures = 0, cyc = 0;
  int rxn0 = 0, cshi0 = 0;
  int run1 = 0, hi_runs = 0, bad_hi = 0, lo2 = 0;
  logic psck1 = 1'b0;
  logic [7:0] rxq1[$];
  logic [7:0] srx0[$];

  spi_master_cmd #(.CLK_DIV(4), .CS_GAP(4)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid[0]), .i_tx_data(tx_data[0]),
    .i_tx_last(tx_last[0]), .o_tx_ready(tx_ready[0]), .o_rx_valid(rx_valid[0]),
    .o_rx_data(rx_data[0]), .o_busy(busy[0]), .o_spi_m_sck(sck[0]), .o_spi_m_cs_n(cs_n[0]),
    .o_spi_m_mosi(mosi[0]), .i_spi_m_miso(miso[0])
  );
  spi_master_cmd #(.CLK_DIV(2), .CS_GAP(4)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid[1]), .i_tx_data(tx_data[1]),
    .i_tx_last(tx_last[1]), .o_tx_ready(tx_ready[1]), .o_rx_valid(rx_valid[1]),
    .o_rx_data(rx_data[1]), .o_busy(busy[1]), .o_spi_m_sck(sck[1]), .o_spi_m_cs_n(cs_n[1]),
    .o_spi_m_mosi(mosi[1]), .i_spi_m_miso(miso[1])
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: first byte of a transaction returns 0x00, later bytes return the LUT response to the previous byte.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic psck = 1'b0, pcs = 1'b1;
    logic [7:0] sin = 8'h00, sout = 8'h00, nxt = 8'h00;
    int cnt = 0;
    always @(negedge clk) begin
      if (pcs && !cs_n[g]) begin
        sout = 8'h00; nxt = 8'h00; sin = 8'h00; cnt = 0;
      end else if (!cs_n[g] && !psck && sck[g]) begin
        sin = {sin[6:0], mosi[g]};
        cnt++;
        if (cnt == 8) begin
          nxt = cmd_rsp(sin);
          cnt = 0;
          if (g == 0) srx0.push_back(sin);
        end
      end else if (!cs_n[g] && psck && !sck[g]) sout = (cnt == 0) ? nxt : {sout[6:0], 1'b0};
      psck = sck[g];
      pcs = cs_n[g];
    end
    assign miso[g] = cs_n[g] ? 1'b0 : sout[7];
  end

  always @(negedge clk) begin
    if (rx_valid[0]) rxn0++;
    if (cs_n[0]) cshi0++;
    if (rx_valid[1]) rxq1.push_back(rx_data[1]);
    if (sck[1] == psck1) run1++;
    else begin
      if (psck1) begin hi_runs++; if (run1 != 2) bad_hi++; end
      else if (run1 == 2) lo2++;
      run1 = 1;
    end
    psck1 = sck[1];
  end

  task automatic send(input int d, input logic [7:0] data, input logic last, output int at, output bit ok);
    ok = 0; at = 0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (tx_ready[d]) begin tx_valid[d] = 1'b1; tx_data[d] = data; tx_last[d] = last; at = cyc; ok = 1; end
    end
    @(negedge clk);
    tx_valid[d] = 1'b0; tx_data[d] = ~data; tx_last[d] = ~last;
  endtask

  task automatic wait_rx(input int d, output logic [7:0] data, output int at, output bit ok);
    ok = 0; at = 0; data = 8'h00;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (rx_valid[d]) begin ok = 1; data = rx_data[d]; at = cyc; end
    end
  endtask

  task automatic idle_wait(input int d, output bit ok);
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin @(negedge clk); if (!busy[d]) ok = 1; end
  endtask

  task automatic test_reset;
    tx_data[0] = 8'h00; tx_data[1] = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (cs_n[0] !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", cs_n[0]); end
    checks++; if (sck[0] !== 1'b0) begin failures++; $display("FAIL reset_sck got=%b exp=0", sck[0]); end
    checks++; if (mosi[0] !== 1'b0) begin failures++; $display("FAIL reset_mosi got=%b exp=0", mosi[0]); end
    checks++; if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", tx_ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy[0]); end
    checks++; if (rx_data[0] !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%h exp=00", rx_data[0]); end
    checks++; if (rxn0 !== 0) begin failures++; $display("FAIL reset_rx_pulses got=%0d exp=0", rxn0); end
  endtask

  task automatic test_two_byte;
    int acc, at, n, cs0, cs1;
    bit ok;
    logic [7:0] d;
    send(0, CMD_WHO_AM_I, 1'b0, acc, ok);
    cs0 = cshi0;
    checks++; if (!ok) begin failures++; $display("FAIL t2_accept0 got=timeout exp=accept"); end
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== 8'h00) begin failures++; $display("FAIL t2_rx0 got=%h ok=%0d exp=00", d, ok); end
    checks++; if (at - acc !== 69) begin failures++; $display("FAIL t2_latency got=%0d exp=69", at - acc); end
    send(0, 8'h00, 1'b1, acc, ok);
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== RSP_WHO_AM_I) begin failures++; $display("FAIL t2_rx1 got=%h ok=%0d exp=8f", d, ok); end
    cs1 = cshi0;
    checks++; if (cs1 !== cs0) begin failures++; $display("FAIL t2_cs_low got=%0d_high_cycles exp=0", cs1 - cs0); end
    n = 0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); n++; if (cs_n[0]) break; end
    checks++; if (n !== 4) begin failures++; $display("FAIL t2_cs_rise got=%0d exp=4", n); end
    idle_wait(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t2_idle got=timeout exp=idle"); end
    checks++; if (srx0.size() < 2 || srx0[srx0.size()-2] !== 8'hF8 || srx0[srx0.size()-1] !== 8'h00)
      begin failures++; $display("FAIL t2_mosi got=%0d_bytes exp=f8,00", srx0.size()); end
  endtask

  task automatic test_back_to_back;
    int acc, acc2, at, n_rdy0, n_gap, n_hi;
    bit ok, got, seen, bad;
    logic [7:0] d, d0;
    send(0, CMD_DBG_A, 1'b1, acc, ok);
    tx_valid[0] = 1'b1; tx_data[0] = CMD_DBG_B; tx_last[0] = 1'b1;
    n_rdy0 = 0; n_gap = 0; n_hi = 0; seen = 0; got = 0; d0 = 8'hFF; acc2 = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rx_valid[0]) begin seen = 1; d0 = rx_data[0]; end
      if (seen && !tx_ready[0]) n_rdy0++;
      if (cs_n[0]) n_hi++;
      if (cs_n[0] && busy[0]) n_gap++;
      if (tx_ready[0]) begin got = 1; acc2 = cyc; end
    end
    checks++; if (!got) begin failures++; $display("FAIL t3_accept got=timeout exp=accept"); end
    checks++; if (d0 !== 8'h00) begin failures++; $display("FAIL t3_rx0 got=%h exp=00", d0); end
    checks++; if (n_rdy0 !== 8) begin failures++; $display("FAIL t3_ready_low got=%0d exp=8", n_rdy0); end
    checks++; if (n_gap !== 4) begin failures++; $display("FAIL t3_gap got=%0d exp=4", n_gap); end
    checks++; if (n_hi !== 5) begin failures++; $display("FAIL t3_cs_high got=%0d exp=5", n_hi); end
    bad = 0;
    for (int j = 1; j <= 9; j++) begin
      @(negedge clk);
      if (j == 1) begin tx_valid[0] = 1'b0; tx_data[0] = 8'h00; end
      if (cs_n[0] !== 1'b0 || sck[0] !== (j == 9)) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL t3_setup got=bad_cs_or_sck exp=fresh_setup"); end
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== 8'h00) begin failures++; $display("FAIL t3_rx1 got=%h ok=%0d exp=00", d, ok); end
    checks++; if (at - acc2 !== 69) begin failures++; $display("FAIL t3_latency got=%0d exp=69", at - acc2); end
    idle_wait(0, ok);
    checks++; if (!ok || srx0.size() < 2 || srx0[srx0.size()-2] !== 8'hAA || srx0[srx0.size()-1] !== 8'h55)
      begin failures++; $display("FAIL t3_mosi got=%0d_bytes ok=%0d exp=aa,55", srx0.size(), ok); end
  endtask

  task automatic test_pause;
    int acc, at;
    bit ok, bad;
    logic [7:0] d;
    send(0, 8'h3C, 1'b0, acc, ok);
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== 8'h00) begin failures++; $display("FAIL t4_rx0 got=%h ok=%0d exp=00", d, ok); end
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (cs_n[0] !== 1'b0 || sck[0] !== 1'b0 || rx_valid[0] !== 1'b0 || tx_ready[0] !== 1'b1) bad = 1;
    end
    checks++; if (bad) begin failures++; $display("FAIL t4_pause got=activity exp=cs_low_sck_low"); end
    send(0, 8'h00, 1'b1, acc, ok);
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== 8'h3C) begin failures++; $display("FAIL t4_rx1 got=%h ok=%0d exp=3c", d, ok); end
    idle_wait(0, ok);
    checks++; if (!ok) begin failures++; $display("FAIL t4_idle got=timeout exp=idle"); end
  endtask

  task automatic test_reset_mid;
    int acc, at, n0;
    bit ok;
    logic [7:0] d;
    send(0, CMD_WHO_AM_I, 1'b1, acc, ok);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    n0 = rxn0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if (cs_n[0] !== 1'b1) begin failures++; $display("FAIL t5_cs_n got=%b exp=1", cs_n[0]); end
    checks++; if (sck[0] !== 1'b0) begin failures++; $display("FAIL t5_sck got=%b exp=0", sck[0]); end
    checks++; if (tx_ready[0] !== 1'b1) begin failures++; $display("FAIL t5_ready got=%b exp=1", tx_ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin failures++; $display("FAIL t5_busy got=%b exp=0", busy[0]); end
    repeat (100) @(negedge clk);
    checks++; if (rxn0 !== n0) begin failures++; $display("FAIL t5_no_rx got=%0d exp=0", rxn0 - n0); end
    send(0, CMD_WHO_AM_I, 1'b1, acc, ok);
    wait_rx(0, d, at, ok);
    checks++; if (!ok || d !== 8'h00) begin failures++; $display("FAIL t5_rx got=%h ok=%0d exp=00", d, ok); end
    checks++; if (at - acc !== 69) begin failures++; $display("FAIL t5_latency got=%0d exp=69", at - acc); end
    idle_wait(0, ok);
    checks++; if (!ok || srx0.size() < 1 || srx0[srx0.size()-1] !== 8'hF8)
      begin failures++; $display("FAIL t5_mosi got=%0d_bytes ok=%0d exp=f8", srx0.size(), ok); end
  endtask

  task automatic test_div2_burst;
    logic [7:0] tx6[8] = '{8'hF8, 8'hAA, 8'h55, 8'h12, 8'h00, 8'hF8, 8'h3C, 8'h00};
    logic [7:0] exp6[8] = '{8'h00, 8'h8F, 8'h55, 8'hAA, 8'h12, 8'h00, 8'h8F, 8'h3C};
    int acc;
    bit ok, all_ok;
    hi_runs = 0; bad_hi = 0; lo2 = 0; rxq1.delete();
    all_ok = 1;
    for (int i = 0; i < 8; i++) begin send(1, tx6[i], i == 7, acc, ok); all_ok &= ok; end
    idle_wait(1, ok);
    repeat (3) @(negedge clk);
    checks++; if (!all_ok || !ok) begin failures++; $display("FAIL t6_handshake got=timeout exp=8_accepts"); end
    checks++; if (rxq1.size() !== 8) begin failures++; $display("FAIL t6_rx_count got=%0d exp=8", rxq1.size()); end
    for (int i = 0; i < 8 && i < rxq1.size(); i++) begin
      checks++; if (rxq1[i] !== exp6[i]) begin failures++; $display("FAIL t6_rx%0d got=%h exp=%h", i, rxq1[i], exp6[i]); end
    end
    checks++; if (hi_runs !== 64 || bad_hi !== 0) begin failures++; $display("FAIL t6_sck_high got=%0d_runs_%0d_bad exp=64_runs_0_bad", hi_runs, bad_hi); end
    checks++; if (lo2 !== 56) begin failures++; $display("FAIL t6_sck_low got=%0d exp=56", lo2); end
  endtask

  initial begin
    test_reset;
    test_two_byte;
    test_back_to_back;
    test_pause;
    test_reset_mid;
    test_div2_burst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
